// File: rtl/mtimer_intc_if.sv
// Bus interface between the core's MMIO data path and the machine timer block.
// One access per cycle: req/we/addr/wdata are driven by the master; rdata/rvalid
// come back from the slave one cycle after a read req.
//   master : drives req, we, addr, wdata; receives rdata, rvalid
//   slave  : receives req, we, addr, wdata; drives rdata, rvalid
interface mtimer_intc_if #(
    parameter int unsigned ADDR_W = 5
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rvalid;

    modport master (
        output req, we, addr, wdata,
        input  rdata, rvalid
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, rvalid
    );
endinterface

// File: rtl/mtimer_intc.sv
// Machine timer and external-interrupt source, reached through MMIO.
// Holds a 64-bit mtime/mtimecmp pair advanced by a prescaler tick, and a latched,
// enableable external-interrupt pending bit fed from an asynchronous pin.
// Optional feature macro: MTIME_SNAPSHOT_EN (MTIME_LO read latches mtime[63:32] into a
// shadow that MTIME_HI reads return, for a coherent 64-bit read).
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   bus        slave side of mtimer_intc_if (req/we/addr/wdata in, rdata/rvalid out)
//   ext_in     asynchronous external interrupt pin
//   timer_intr machine timer interrupt, level
//   ext_intr   machine external interrupt, level
// Register map by addr[4:2]: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
// 4 PRESCALE, 5 CTRL {EIP(w1c), EIE, TIE}, 6-7 reserved (read 0).
module mtimer_intc #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned PRESCALE_W   = 16,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rstn,
    mtimer_intc_if.slave bus,
    input  logic        ext_in,
    output logic        timer_intr,
    output logic        ext_intr
);
    logic [2:0] sel;
    logic       wr, rd, tick, rise;

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  tie_q, tie_d, eie_q, eie_d, eip_q, eip_d;
    logic                  s1_q, s2_q, s3_q;
    logic [31:0]           rdata_q, rdata_d;
    logic                  rvalid_q;
    logic                  timer_intr_q, ext_intr_q;
    logic [31:0]           mtime_hi_rd;

    assign sel = bus.addr[4:2];
    assign wr  = bus.req && bus.we;
    assign rd  = bus.req && !bus.we;

    // s1/s2 synchronise the pin; s3 is the previous synchronised level for edge detect.
    assign rise = s2_q && !s3_q;

`ifdef MTIME_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (rd && sel == 3'd0) shadow_d = mtime_q[63:32];
        if (wr && sel == 3'd1) shadow_d = bus.wdata;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) shadow_q <= '0;
        else       shadow_q <= shadow_d;
    end

    assign mtime_hi_rd = shadow_q;
`else
    assign mtime_hi_rd = mtime_q[63:32];
`endif

    always_comb begin
        tick = (pcnt_q == prescale_q);

        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        if (wr && sel == 3'd4) pcnt_d = '0;

        // A bus write to either mtime half suppresses that cycle's increment.
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr && sel == 3'd0) mtime_d = {mtime_q[63:32], bus.wdata};
        if (wr && sel == 3'd1) mtime_d = {bus.wdata, mtime_q[31:0]};

        mtimecmp_d = mtimecmp_q;
        if (wr && sel == 3'd2) mtimecmp_d[31:0]  = bus.wdata;
        if (wr && sel == 3'd3) mtimecmp_d[63:32] = bus.wdata;

        prescale_d = prescale_q;
        if (wr && sel == 3'd4) prescale_d = bus.wdata[PRESCALE_W-1:0];

        tie_d = tie_q;
        eie_d = eie_q;
        eip_d = eip_q;
        if (wr && sel == 3'd5) begin
            tie_d = bus.wdata[0];
            eie_d = bus.wdata[1];
            if (bus.wdata[2]) eip_d = 1'b0;
        end
        // A new edge beats a simultaneous clear so no interrupt is lost.
        if (rise) eip_d = 1'b1;

        rdata_d = rdata_q;
        if (rd) begin
            case (sel)
                3'd0:    rdata_d = mtime_q[31:0];
                3'd1:    rdata_d = mtime_hi_rd;
                3'd2:    rdata_d = mtimecmp_q[31:0];
                3'd3:    rdata_d = mtimecmp_q[63:32];
                3'd4:    rdata_d = 32'(prescale_q);
                3'd5:    rdata_d = {29'd0, eip_q, eie_q, tie_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mtime_q      <= '0;
            mtimecmp_q   <= MTIMECMP_RST;
            prescale_q   <= '0;
            pcnt_q       <= '0;
            tie_q        <= 1'b0;
            eie_q        <= 1'b0;
            eip_q        <= 1'b0;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
            timer_intr_q <= 1'b0;
            ext_intr_q   <= 1'b0;
        end else begin
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            prescale_q   <= prescale_d;
            pcnt_q       <= pcnt_d;
            tie_q        <= tie_d;
            eie_q        <= eie_d;
            eip_q        <= eip_d;
            s1_q         <= ext_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            rdata_q      <= rdata_d;
            rvalid_q     <= rd;
            // Compare on registered state, so results trail a change by one cycle.
            timer_intr_q <= tie_q && (mtime_q >= mtimecmp_q);
            ext_intr_q   <= eie_q && eip_q;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign timer_intr = timer_intr_q;
    assign ext_intr   = ext_intr_q;
endmodule

// File: tb/tb_mtimer_intc.sv
// Self-checking bench for mtimer_intc: reads push their expected data and due cycle
// into a scoreboard queue; a monitor pops and compares on every rvalid.
module tb_mtimer_intc;
    logic clk = 1'b0;
    logic rstn;
    logic ext_in;
    logic timer_intr, ext_intr;

    mtimer_intc_if #(.ADDR_W(5)) bus ();

    mtimer_intc dut (
        .clk        (clk),
        .rstn       (rstn),
        .bus        (bus),
        .ext_in     (ext_in),
        .timer_intr (timer_intr),
        .ext_intr   (ext_intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every rvalid must match the oldest outstanding read, on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rvalid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid actual=1 required=0");
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_data"}, bus.rdata, e.data);
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    // Access tasks are entered between edges and return #1 after the sampling edge.
    task automatic bus_write(input logic [2:0] idx, input logic [31:0] data);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = {idx, 2'b00};
        bus.wdata = data;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        bus.we  = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] idx, input logic [31:0] exp, input string name);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = {idx, 2'b00};
        sb_q.push_back('{name, exp, cyc + 1});
        @(posedge clk);
        #1;
        bus.req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_at_neg(input string name, input logic act_sel, input logic exp);
        @(negedge clk);
        chk(name, 32'(act_sel ? ext_intr : timer_intr), 32'(exp));
    endtask

    initial begin
        int highs;
        rstn      = 1'b0;
        ext_in    = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        bus_read(3'd5, 32'h0, "rst_ctrl");
        bus_read(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
        bus_read(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
        highs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (timer_intr || ext_intr) highs++;
        end
        chk("rst_intr_quiet", 32'(highs), 32'd0);
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, 32'h0, "rsvd6");
        bus_read(3'd7, 32'h0, "rsvd7");

        // Prescale 3: ticks every 4 cycles, 10 ticks over the idle window.
        bus_write(3'd4, 32'd3);
        bus_write(3'd0, 32'd0);
        idle(40);
        bus_read(3'd0, 32'd10, "ps3_mtime");
        bus_read(3'd4, 32'd3, "ps3_reg");

        // Prescale 0: ticks every cycle.
        bus_write(3'd4, 32'd0);
        bus_write(3'd0, 32'd0);
        idle(40);
        bus_read(3'd0, 32'd40, "ps0_mtime");

        // Timer compare at 50; mtime reaches 50 fifty edges after the LO write.
        bus_write(3'd3, 32'd0);
        bus_write(3'd2, 32'd50);
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'd0);
        bus_write(3'd5, 32'd1);
        idle(49);
        chk_at_neg("timer_before", 1'b0, 1'b0);
        idle(1);
        chk_at_neg("timer_rise", 1'b0, 1'b1);
        bus_write(3'd2, 32'd1000);
        chk_at_neg("timer_hold", 1'b0, 1'b1);
        idle(1);
        chk_at_neg("timer_fall", 1'b0, 1'b0);

        // Wrap and carry.
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'hFFFF_FFFE);
        idle(1);
        bus_read(3'd0, 32'hFFFF_FFFF, "wrap_lo");
`ifdef MTIME_SNAPSHOT_EN
        bus_read(3'd1, 32'd0, "wrap_hi_snap");
`else
        bus_read(3'd1, 32'd1, "wrap_hi_live");
`endif
        bus_read(3'd0, 32'd1, "carry_lo");
        bus_read(3'd1, 32'd1, "carry_hi");

        // External path: EIE only.
        bus_write(3'd5, 32'd2);
        ext_in = 1'b1;
        idle(3);
        chk_at_neg("ext_before", 1'b1, 1'b0);
        idle(1);
        chk_at_neg("ext_rise", 1'b1, 1'b1);
        idle(1);
        ext_in = 1'b0;
        idle(5);
        chk_at_neg("ext_sticky", 1'b1, 1'b1);
        bus_read(3'd5, 32'd6, "ctrl_eip_set");
        bus_write(3'd5, 32'd6);
        idle(1);
        chk_at_neg("ext_cleared", 1'b1, 1'b0);
        bus_read(3'd5, 32'd2, "ctrl_eip_clr");
        // New rise lands in the same cycle as a clear: set wins.
        ext_in = 1'b1;
        idle(2);
        bus_write(3'd5, 32'd6);
        bus_read(3'd5, 32'd6, "ctrl_set_wins");
        // Held level does not re-set after a clear.
        bus_write(3'd5, 32'd6);
        bus_read(3'd5, 32'd2, "ctrl_level_once");

        // Async reset mid-run with both interrupts high.
        bus_write(3'd5, 32'd3);
        ext_in = 1'b0;
        idle(3);
        ext_in = 1'b1;
        idle(5);
        chk_at_neg("pre_rst_timer", 1'b0, 1'b1);
        chk("pre_rst_ext", 32'(ext_intr), 32'd1);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = {3'd5, 2'b00};
        #2 rstn   = 1'b0;
        ext_in    = 1'b0;
        #1;
        chk("rst_async_timer", 32'(timer_intr), 32'd0);
        chk("rst_async_ext", 32'(ext_intr), 32'd0);
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        @(negedge clk);
        chk("rst_no_rvalid", 32'(bus.rvalid), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        bus_read(3'd3, 32'hFFFF_FFFF, "post_rst_cmp_hi");
        bus_read(3'd5, 32'h0, "post_rst_ctrl");
        bus_read(3'd4, 32'h0, "post_rst_prescale");

        idle(3);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mtimer_intc.md
Name: mtimer_intc

Overview:
- Memory-mapped machine timer and external-interrupt source. It generates the `timer_intr` and `ext_intr` level lines consumed by `core`.
- The core's data bus reaches it through MMIO loads and stores. It holds a 64-bit mtime/mtimecmp pair, a prescaler, and a latched, enableable external-interrupt pending bit fed from an asynchronous pin.

Parameters:
- ADDR_W, 5, byte-address width of the register window. Decode uses addr[4:2].
- PRESCALE_W, 16, width of the prescaler reload register and counter.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp. The default means no timer interrupt after reset.

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- req  in  1  bus access strobe, one access per cycle
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  byte address; bits [1:0] ignored
- wdata  in  32  write data; full-word writes only
- rdata  out  32  read data, valid when rvalid
- rvalid  out  1  one-cycle pulse, one cycle after a read req
- ext_in  in  1  asynchronous external interrupt pin
- timer_intr  out  1  machine timer interrupt, level
- ext_intr  out  1  machine external interrupt, level

Behaviour:
- Register map, by addr[4:2]:
  - 0 MTIME_LO
  - 1 MTIME_HI
  - 2 MTIMECMP_LO
  - 3 MTIMECMP_HI
  - 4 PRESCALE (PRESCALE_W bits, zero-extended on read)
  - 5 CTRL: bit0 TIE, bit1 EIE, bit2 EIP (write-1-to-clear), others read 0
  - 6–7: reads return 0, writes are ignored
- Reset values:
  - mtime = 0; mtimecmp = MTIMECMP_RST; PRESCALE = 0; prescale counter = 0
  - TIE = 0, EIE = 0, EIP = 0; synchronizer flops = 0
  - rdata = 0, rvalid = 0, timer_intr = 0, ext_intr = 0
- Reads:
  - A read req in cycle N gives registered rdata and rvalid = 1 in cycle N+1.
  - rdata holds its value until the next read; rvalid is 0 otherwise.
  - Back-to-back reads give back-to-back rvalid pulses.
- Writes take effect at the clock edge ending the req cycle. No rvalid is generated for a write.
- Prescaler:
  - The counter increments every cycle.
  - When counter == PRESCALE: the counter goes to 0 and tick = 1 for that cycle.
  - PRESCALE = 0 therefore ticks every cycle.
  - A PRESCALE write also clears the counter.
- mtime:
  - Increments by 1 on tick. Wraps from 2^64-1 to 0.
  - Carry from LO to HI happens in the same cycle.
  - A bus write to MTIME_LO or MTIME_HI in the same cycle as a tick wins: the written half takes wdata, the other half keeps its old value, and there is no increment that cycle.
- timer_intr:
  - Registered as TIE && (mtime >= mtimecmp), unsigned 64-bit compare, using the register values after the current edge.
  - Compare results become visible one cycle after an mtime, mtimecmp or TIE change.
- External path:
  - ext_in passes through 2 flops (s1, s2), then an edge-detect flop s3.
  - rise = s2 && !s3 sets EIP. Latency from a stable ext_in high to EIP = 1 is 3 edges.
  - A CTRL write with bit2 = 1 clears EIP. If rise and clear happen in the same cycle, set wins.
  - Bits 0–1 of every CTRL write load TIE/EIE.
  - ext_intr is registered as EIE && EIP.
  - A level held high sets EIP only once; re-arming needs a falling then a rising edge.
- rstn asserted mid-operation forces all state to reset values immediately. A read pending at that moment produces no rvalid.

Optional Feature:
- MTIME_SNAPSHOT_EN
- Defined:
  - A read of MTIME_LO also latches the current mtime[63:32] into a shadow register.
  - A subsequent MTIME_HI read returns the shadow, giving a coherent 64-bit read across an LO→HI carry.
  - Shadow resets to 0. An MTIME_HI write updates the shadow too.
- Undefined: MTIME_HI read returns live mtime[63:32]; no shadow flop exists.

Test Plan:
- Reset: after rstn release, read CTRL -> rvalid next cycle, rdata = 0. Read MTIMECMP_HI -> 32'hFFFF_FFFF. timer_intr = 0 and ext_intr = 0 for 100 cycles.
- Prescale: write PRESCALE = 3 and MTIME_LO = 0, then idle 40 cycles -> MTIME_LO reads 10 (±1 for access cycle). With PRESCALE = 0 over 40 cycles -> 40.
- Timer: MTIMECMP_HI = 0, MTIMECMP_LO = 50, MTIME = 0, TIE = 1 -> timer_intr rises exactly one cycle after mtime reaches 50. Writing MTIMECMP_LO = 1000 -> timer_intr falls next cycle.
- Wrap and carry: MTIME_HI = 0, MTIME_LO = 32'hFFFF_FFFE, PRESCALE = 0 -> two cycles later MTIME_HI = 1, MTIME_LO = 0. With MTIME_SNAPSHOT_EN, reading LO at FFFF_FFFF then HI returns HI = 0.
- External: EIE = 1, ext_in pulses high for 5 cycles -> ext_intr = 1 four edges after the rise and stays high after ext_in falls. A CTRL write of 0x6 -> ext_intr = 0 next cycle. A clear coinciding with a new rise -> EIP stays 1.
- Async reset mid-run: with timer_intr = 1 and EIP = 1, drop rstn between edges -> both outputs 0 without a clock edge. A read issued in the reset cycle gives no rvalid.
